// File: rtl/regfile_mp_if.sv
// Bus bundle between the decode/writeback side and the regfile_mp register bank.
//   master : drives clear request, both write ports and the read addresses,
//            receives read data and ready.
//   slave  : the register bank itself.
// Members:
//   i_clear              re-clear request (honoured only when ready)
//   i_we0/i_waddr0/i_wdata0   write port 0
//   i_we1/i_waddr1/i_wdata1   write port 1 (wins on same-address conflict)
//   i_raddr[READ_PORTS]  read addresses
//   o_rdata[READ_PORTS]  read data (combinational)
//   o_ready              clear finished, writes accepted, reads valid
interface regfile_mp_if #(
    parameter int ADDR_WIDTH = 4,
    parameter int WORD_WIDTH = 32,
    parameter int READ_PORTS = 2
);
    logic                                   i_clear;
    logic                                   i_we0;
    logic [ADDR_WIDTH-1:0]                  i_waddr0;
    logic [WORD_WIDTH-1:0]                  i_wdata0;
    logic                                   i_we1;
    logic [ADDR_WIDTH-1:0]                  i_waddr1;
    logic [WORD_WIDTH-1:0]                  i_wdata1;
    logic [READ_PORTS-1:0][ADDR_WIDTH-1:0]  i_raddr;
    logic [READ_PORTS-1:0][WORD_WIDTH-1:0]  o_rdata;
    logic                                   o_ready;

    modport master (
        output i_clear, i_we0, i_waddr0, i_wdata0, i_we1, i_waddr1, i_wdata1, i_raddr,
        input  o_rdata, o_ready
    );

    modport slave (
        input  i_clear, i_we0, i_waddr0, i_wdata0, i_we1, i_waddr1, i_wdata1, i_raddr,
        output o_rdata, o_ready
    );
endinterface

// File: rtl/regfile_mp.sv
// Multi-port register bank: SIZE words, two write ports (port 1 has priority),
// READ_PORTS combinational read ports, optional hardwired-zero entry 0 and
// optional write-to-read bypass. Storage is zeroed by a sequential clear
// engine (one entry per cycle) after reset or on i_clear, so the array only
// ever needs one extra write port for clearing.
// Ports:
//   i_clk   clock, all state on rising edge
//   i_rst   synchronous active-high reset, restarts the clear walk
//   io_bus  regfile_mp_if.slave (write ports, read ports, clear, ready)

// Per-read-port output select: zero entry, out-of-range, bypass, stored.
module regfile_mp_rdport #(
    parameter int ADDR_WIDTH = 4,
    parameter int WORD_WIDTH = 32,
    parameter int SIZE       = 1 << ADDR_WIDTH,
    parameter int ZERO_REG   = 1,
    parameter int BYPASS     = 1
) (
    input  logic                  i_ready,
    input  logic [ADDR_WIDTH-1:0] i_raddr,
    input  logic [WORD_WIDTH-1:0] i_stored,
    input  logic                  i_wen0,
    input  logic [ADDR_WIDTH-1:0] i_waddr0,
    input  logic [WORD_WIDTH-1:0] i_wdata0,
    input  logic                  i_wen1,
    input  logic [ADDR_WIDTH-1:0] i_waddr1,
    input  logic [WORD_WIDTH-1:0] i_wdata1,
    output logic [WORD_WIDTH-1:0] o_rdata
);
    localparam logic [ADDR_WIDTH:0] SIZE_L = (ADDR_WIDTH+1)'(SIZE);

    always_comb begin
        o_rdata = '0;
        if (!i_ready)
            o_rdata = '0;
        else if (ZERO_REG != 0 && i_raddr == '0)
            o_rdata = '0;
        else if ({1'b0, i_raddr} >= SIZE_L)
            o_rdata = '0;
        else if (BYPASS != 0 && i_wen1 && i_waddr1 == i_raddr)
            o_rdata = i_wdata1;
        else if (BYPASS != 0 && i_wen0 && i_waddr0 == i_raddr)
            o_rdata = i_wdata0;
        else
            o_rdata = i_stored;
    end
endmodule

module regfile_mp #(
    parameter int ADDR_WIDTH = 4,
    parameter int WORD_WIDTH = 32,
    parameter int SIZE       = 1 << ADDR_WIDTH,
    parameter int READ_PORTS = 2,
    parameter int ZERO_REG   = 1,
    parameter int BYPASS     = 1
) (
    input  logic          i_clk,
    input  logic          i_rst,
    regfile_mp_if.slave   io_bus
);
    localparam logic [ADDR_WIDTH:0] SIZE_L = (ADDR_WIDTH+1)'(SIZE);
    localparam logic [ADDR_WIDTH:0] LAST   = SIZE_L - 1'b1;

    typedef enum logic {S_CLEAR = 1'b0, S_READY = 1'b1} state_t;

    state_t                r_state, w_state_nxt;
    // One bit wider than the address so SIZE == 2**ADDR_WIDTH cannot wrap early.
    logic [ADDR_WIDTH:0]   r_ptr;
    logic [WORD_WIDTH-1:0] r_mem [SIZE];

    logic                  w_clr_we;
    logic                  w_we0_ok, w_we1_ok;
    logic                  w_ready;
    logic [WORD_WIDTH-1:0] w_rdata [READ_PORTS];

    // Address accepted for storage: in range and not the hardwired zero entry.
    function automatic logic addr_ok(input logic [ADDR_WIDTH-1:0] a);
        return ({1'b0, a} < SIZE_L) && !(ZERO_REG != 0 && a == '0);
    endfunction

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= S_CLEAR;
        else       r_state <= w_state_nxt;
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_CLEAR: if (r_ptr == LAST)   w_state_nxt = S_READY;
            S_READY: if (io_bus.i_clear)  w_state_nxt = S_CLEAR;
            default:                      w_state_nxt = S_CLEAR;
        endcase
    end

    // Output decode. A clear request in READY drops that cycle's writes.
    always_comb begin
        w_ready  = (r_state == S_READY);
        w_clr_we = (r_state == S_CLEAR);
        w_we0_ok = w_ready && !io_bus.i_clear && io_bus.i_we0 && addr_ok(io_bus.i_waddr0);
        w_we1_ok = w_ready && !io_bus.i_clear && io_bus.i_we1 && addr_ok(io_bus.i_waddr1);
    end

    // ptr is parked at 0 in READY, so a clear request always starts at entry 0.
    always_ff @(posedge i_clk) begin
        if (i_rst || r_state == S_READY) r_ptr <= '0;
        else                             r_ptr <= r_ptr + 1'b1;
    end

    // Storage: no reset, contents defined only by the clear walk.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            if (w_clr_we) begin
                r_mem[r_ptr[ADDR_WIDTH-1:0]] <= '0;
            end else begin
                if (w_we0_ok) r_mem[io_bus.i_waddr0] <= io_bus.i_wdata0;
                // Issued after port 0 so it wins a same-address conflict.
                if (w_we1_ok) r_mem[io_bus.i_waddr1] <= io_bus.i_wdata1;
            end
        end
    end

    for (genvar k = 0; k < READ_PORTS; k++) begin : g_rd
        logic [WORD_WIDTH-1:0] w_stored;
        assign w_stored = ({1'b0, io_bus.i_raddr[k]} < SIZE_L) ? r_mem[io_bus.i_raddr[k]] : '0;

        regfile_mp_rdport #(
            .ADDR_WIDTH (ADDR_WIDTH),
            .WORD_WIDTH (WORD_WIDTH),
            .SIZE       (SIZE),
            .ZERO_REG   (ZERO_REG),
            .BYPASS     (BYPASS)
        ) u_rd (
            .i_ready  (w_ready),
            .i_raddr  (io_bus.i_raddr[k]),
            .i_stored (w_stored),
            .i_wen0   (w_we0_ok),
            .i_waddr0 (io_bus.i_waddr0),
            .i_wdata0 (io_bus.i_wdata0),
            .i_wen1   (w_we1_ok),
            .i_waddr1 (io_bus.i_waddr1),
            .i_wdata1 (io_bus.i_wdata1),
            .o_rdata  (w_rdata[k])
        );
    end

    always_comb begin
        io_bus.o_rdata = '0;
        for (int k = 0; k < READ_PORTS; k++) io_bus.o_rdata[k] = w_rdata[k];
    end

    assign io_bus.o_ready = w_ready;
endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp. Four instances share one stimulus:
//   0: defaults (ZERO_REG=1, BYPASS=1, SIZE=16)
//   1: ZERO_REG=0
//   2: BYPASS=0
//   3: SIZE=12 (exercises out-of-range addresses)
module tb_regfile_mp;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clear = 1'b0;
    logic        we0 = 1'b0, we1 = 1'b0;
    logic [3:0]  waddr0 = '0, waddr1 = '0;
    logic [31:0] wdata0 = '0, wdata1 = '0;
    logic [3:0]  raddr0 = '0, raddr1 = '0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    regfile_mp_if #(.ADDR_WIDTH(4), .WORD_WIDTH(32), .READ_PORTS(2)) bus [4] ();

    for (genvar i = 0; i < 4; i++) begin : g_drv
        assign bus[i].i_clear  = clear;
        assign bus[i].i_we0    = we0;
        assign bus[i].i_waddr0 = waddr0;
        assign bus[i].i_wdata0 = wdata0;
        assign bus[i].i_we1    = we1;
        assign bus[i].i_waddr1 = waddr1;
        assign bus[i].i_wdata1 = wdata1;
        assign bus[i].i_raddr  = {raddr1, raddr0};
    end

    regfile_mp #(.ZERO_REG(1), .BYPASS(1)) u_dut (.i_clk(clk), .i_rst(rst), .io_bus(bus[0]));
    regfile_mp #(.ZERO_REG(0), .BYPASS(1)) u_nz  (.i_clk(clk), .i_rst(rst), .io_bus(bus[1]));
    regfile_mp #(.ZERO_REG(1), .BYPASS(0)) u_nb  (.i_clk(clk), .i_rst(rst), .io_bus(bus[2]));
    regfile_mp #(.SIZE(12))                u_sm  (.i_clk(clk), .i_rst(rst), .io_bus(bus[3]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge, leave time for registered outputs to settle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_off();
        we0 = 1'b0;
        we1 = 1'b0;
    endtask

    initial begin
        // Reset held for 3 cycles, with a write pending the whole time.
        we0 = 1'b1; waddr0 = 4'd2; wdata0 = 32'hBAD;
        raddr0 = 4'd2; raddr1 = 4'd15;
        repeat (3) tick();
        chk("rst_ready", 32'(bus[0].o_ready), 32'd0);
        chk("rst_rd0",   bus[0].o_rdata[0],   32'd0);
        chk("rst_rd1",   bus[0].o_rdata[1],   32'd0);
        rst = 1'b0;

        // Clear walk: ready only after the 16th edge, writes ignored meanwhile.
        for (int i = 1; i <= 16; i++) begin
            tick();
            if (i == 16) wr_off();
            #1;
            chk($sformatf("clr_ready_%0d", i), 32'(bus[0].o_ready), (i == 16) ? 32'd1 : 32'd0);
            chk($sformatf("clr_rd_%0d", i),    bus[0].o_rdata[0],   32'd0);
        end
        chk("post_clr_a2",  bus[0].o_rdata[0], 32'd0);
        chk("post_clr_a15", bus[0].o_rdata[1], 32'd0);

        // Write conflict on address 5: port 1 wins (bypass and stored).
        we0 = 1'b1; waddr0 = 4'd5; wdata0 = 32'hAAAA0000;
        we1 = 1'b1; waddr1 = 4'd5; wdata1 = 32'h5555FFFF;
        raddr0 = 4'd5;
        #1;
        chk("conf_byp",    bus[0].o_rdata[0], 32'h5555FFFF);
        chk("conf_nobyp",  bus[2].o_rdata[0], 32'd0);
        tick(); wr_off(); #1;
        chk("conf_next",    bus[0].o_rdata[0], 32'h5555FFFF);
        chk("conf_next_nb", bus[2].o_rdata[0], 32'h5555FFFF);

        // Dual write to distinct addresses.
        we0 = 1'b1; waddr0 = 4'd3; wdata0 = 32'h11;
        we1 = 1'b1; waddr1 = 4'd7; wdata1 = 32'h22;
        raddr0 = 4'd3; raddr1 = 4'd7;
        tick(); wr_off(); #1;
        chk("dual_rd0",   bus[0].o_rdata[0], 32'h11);
        chk("dual_rd1",   bus[0].o_rdata[1], 32'h22);
        chk("dual_sm_rd1", bus[3].o_rdata[1], 32'h22);

        // Zero register.
        we0 = 1'b1; waddr0 = 4'd0; wdata0 = 32'hDEADBEEF;
        raddr0 = 4'd0;
        #1;
        chk("zero_byp",    bus[0].o_rdata[0], 32'd0);
        chk("zero_nz_byp", bus[1].o_rdata[0], 32'hDEADBEEF);
        tick(); wr_off(); #1;
        chk("zero_next",    bus[0].o_rdata[0], 32'd0);
        chk("zero_nz_next", bus[1].o_rdata[0], 32'hDEADBEEF);
        chk("zero_nb_next", bus[2].o_rdata[0], 32'd0);

        // Bypass: address 9 holds 1, then 2 is written while reading it.
        we0 = 1'b1; waddr0 = 4'd9; wdata0 = 32'h1;
        tick();
        wdata0 = 32'h2; raddr0 = 4'd9;
        #1;
        chk("byp_same",    bus[0].o_rdata[0], 32'h2);
        chk("byp_nb_same", bus[2].o_rdata[0], 32'h1);
        tick(); wr_off(); #1;
        chk("byp_next",    bus[0].o_rdata[0], 32'h2);
        chk("byp_nb_next", bus[2].o_rdata[0], 32'h2);

        // Out-of-range on SIZE=12: address 13 dropped even with bypass, 11 is last valid.
        we0 = 1'b1; waddr0 = 4'd13; wdata0 = 32'hC0FFEE;
        we1 = 1'b1; waddr1 = 4'd11; wdata1 = 32'hB;
        raddr0 = 4'd13; raddr1 = 4'd11;
        #1;
        chk("oor_sm_same",  bus[3].o_rdata[0], 32'd0);
        chk("oor_dut_same", bus[0].o_rdata[0], 32'hC0FFEE);
        tick(); wr_off(); #1;
        chk("oor_sm_next",  bus[3].o_rdata[0], 32'd0);
        chk("oor_sm_last",  bus[3].o_rdata[1], 32'hB);
        chk("oor_dut_next", bus[0].o_rdata[0], 32'hC0FFEE);

        // i_clear with a concurrent write to address 4.
        clear = 1'b1; we0 = 1'b1; waddr0 = 4'd4; wdata0 = 32'h77;
        raddr0 = 4'd4; raddr1 = 4'd5;
        tick();
        clear = 1'b0; wr_off(); #1;
        chk("clrq_drop", 32'(bus[0].o_ready), 32'd0);
        for (int i = 1; i <= 16; i++) begin
            tick();
            chk($sformatf("clrq_ready_%0d", i), 32'(bus[0].o_ready), (i == 16) ? 32'd1 : 32'd0);
        end
        chk("clrq_a4", bus[0].o_rdata[0], 32'd0);
        chk("clrq_a5", bus[0].o_rdata[1], 32'd0);

        // Reset pulse midway through a clear restarts the count.
        we0 = 1'b1; waddr0 = 4'd5; wdata0 = 32'h33;
        tick(); wr_off(); #1;
        chk("pre_rst_a5", bus[0].o_rdata[1], 32'h33);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        repeat (8) tick();
        chk("mid_clr_ready", 32'(bus[0].o_ready), 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            tick();
            chk($sformatf("rst_ready_%0d", i), 32'(bus[0].o_ready), (i == 16) ? 32'd1 : 32'd0);
        end
        chk("final_a5", bus[0].o_rdata[1], 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
